// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader: takes a length-prefixed, XOR-checked byte stream and writes
// big-endian 32-bit words into instruction memory. cpu_reset is released only after the image verifies.
module imem_boot_loader #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_waddr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int WL_W  = ADDR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [16:0]      CAPACITY = 17'(2 ** ADDR_W);
    localparam logic [WL_W-1:0]  WL_ONE   = WL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [WL_W-1:0]   len_q, len_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       shift_q, shift_d;
    logic [7:0]        acc_q, acc_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              in_ready_q, in_ready_d;
    logic              im_we_q, im_we_d;
    logic [ADDR_W-1:0] im_waddr_q, im_waddr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [WL_W-1:0]   words_loaded_q, words_loaded_d;

    logic              accept;
    logic [15:0]       frame_len;
    logic [WL_W-1:0]   wl_next;

    assign accept    = in_valid && in_ready_q;
    assign frame_len = {len_hi_q, in_data};
    assign wl_next   = words_loaded_q + WL_ONE;

    always_comb begin
        // NOTE: every _d starts from a default so no path leaves a signal unassigned (no latches).
        state_d        = state_q;
        len_hi_d       = len_hi_q;
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        shift_d        = shift_q;
        acc_d          = acc_q;
        tmo_d          = '0;
        im_we_d        = 1'b0;
        im_waddr_d     = im_waddr_q;
        im_wdata_d     = im_wdata_q;
        words_loaded_d = words_loaded_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d        = S_LEN_HI;
                    words_loaded_d = '0;
                    acc_d          = '0;
                    byte_idx_d     = '0;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = WL_W'(frame_len);
                    if ({1'b0, frame_len} > CAPACITY) begin
                        state_d = S_ERROR;
                    end else if (frame_len == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    acc_d      = acc_q ^ in_data;
                    shift_d    = {shift_q[15:0], in_data};
                    byte_idx_d = byte_idx_q + 2'd1;
                    // The fourth byte completes a word; it is written on the following cycle.
                    if (byte_idx_q == 2'd3) begin
                        im_we_d        = 1'b1;
                        im_waddr_d     = words_loaded_q[ADDR_W-1:0];
                        im_wdata_d     = {shift_q, in_data};
                        words_loaded_d = wl_next;
                        if (wl_next == len_q) begin
                            state_d = S_CHECK;
                        end
                    end
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte watchdog: armed once the length header has started, restarted by every byte.
        if ((state_q == S_LEN_LO || state_q == S_DATA || state_q == S_CHECK) && !accept) begin
            if (tmo_q == TMO_LAST) begin
                state_d = S_ERROR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        in_ready_d  = (state_d == S_LEN_HI) || (state_d == S_LEN_LO) ||
                      (state_d == S_DATA)   || (state_d == S_CHECK);
        cpu_reset_d = (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
        if (reset) begin
            state_q        <= S_IDLE;
            len_hi_q       <= '0;
            len_q          <= '0;
            byte_idx_q     <= '0;
            shift_q        <= '0;
            acc_q          <= '0;
            tmo_q          <= '0;
            in_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_waddr_q     <= '0;
            im_wdata_q     <= '0;
            cpu_reset_q    <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            state_q        <= state_d;
            len_hi_q       <= len_hi_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            shift_q        <= shift_d;
            acc_q          <= acc_d;
            tmo_q          <= tmo_d;
            in_ready_q     <= in_ready_d;
            im_we_q        <= im_we_d;
            im_waddr_q     <= im_waddr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_reset_q    <= cpu_reset_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = im_we_q;
    assign im_waddr     = im_waddr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frame-level reference model compared every cycle,
// plus literal expectations for the hand-built frames.
module tb_imem_boot_loader;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 16;
    localparam int CAP     = 1 << ADDR_W;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_waddr;
    logic [31:0]       im_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_waddr     (im_waddr),
        .im_wdata     (im_wdata),
        .cpu_reset    (cpu_reset),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (frame/byte-count level) ----------------
    typedef enum {R_NONE, R_DONE, R_ERR} result_e;

    bit          m_loading = 1'b0;
    result_e     m_result  = R_NONE;
    logic [7:0]  m_frame[$];
    int          m_len     = 0;
    int          m_idle    = 0;
    int          m_wl      = 0;
    bit          m_we      = 1'b0;
    int          m_waddr   = 0;
    logic [31:0] m_wdata   = '0;

    int          wr_addr_log[$];
    logic [31:0] wr_data_log[$];

    // Advance the model by the clock edge that follows; inputs are stable at this point.
    task automatic model_step();
        int k;
        logic [7:0] b;
        logic [7:0] x;
        m_we = 1'b0;
        if (reset) begin
            m_loading = 1'b0;
            m_result  = R_NONE;
            m_wl      = 0;
            m_idle    = 0;
            m_frame.delete();
            return;
        end
        if (!m_loading) begin
            if (start) begin
                m_loading = 1'b1;
                m_result  = R_NONE;
                m_wl      = 0;
                m_idle    = 0;
                m_frame.delete();
            end
            return;
        end
        if (!in_valid) begin
            if (m_frame.size() >= 1) begin
                m_idle++;
                if (m_idle == TIMEOUT) begin
                    m_loading = 1'b0;
                    m_result  = R_ERR;
                end
            end
            return;
        end
        m_idle = 0;
        b = in_data;
        k = m_frame.size();
        m_frame.push_back(b);
        if (k == 1) begin
            m_len = int'(m_frame[0]) * 256 + int'(b);
            if (m_len > CAP) begin
                m_loading = 1'b0;
                m_result  = R_ERR;
            end
        end else if (k >= 2 && k < 2 + 4 * m_len) begin
            if ((k - 2) % 4 == 3) begin
                m_we    = 1'b1;
                m_waddr = (k - 2) / 4;
                m_wdata = {m_frame[k-3], m_frame[k-2], m_frame[k-1], m_frame[k]};
                m_wl++;
            end
        end else if (k == 2 + 4 * m_len) begin
            x = 8'h00;
            for (int i = 2; i < k; i++) x ^= m_frame[i];
            m_loading = 1'b0;
            m_result  = (b == x) ? R_DONE : R_ERR;
        end
    endtask

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("in_ready", in_ready, m_loading);
            check("cpu_reset", cpu_reset, m_result != R_DONE);
            check("done", done, m_result == R_DONE);
            check("error", error, m_result == R_ERR);
            check("words_loaded", words_loaded, m_wl);
            check("im_we", im_we, m_we);
            if (m_we) begin
                check("im_waddr", im_waddr, m_waddr);
                check("im_wdata", im_wdata, m_wdata);
            end
            if (im_we === 1'b1) begin
                wr_addr_log.push_back(int'(im_waddr));
                wr_data_log.push_back(im_wdata);
            end
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] tx[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        bit hs;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
        repeat (gap) step();
        in_valid = 1'b1;
        in_data  = b;
        for (int g = 0; ; g++) begin
            @(negedge clk);
            hs = (in_ready === 1'b1);
            step();
            if (hs) break;
            if (g >= 200) begin
                tests++;
                fails++;
                $display("FAIL handshake_wait: in_ready never rose, got %0b expected 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send_tx(input int max_gap, input int start_at);
        for (int i = 0; i < tx.size(); i++) begin
            if (i == start_at) pulse_start();
            send_byte(tx[i], max_gap);
        end
    endtask

    task automatic frame_a(input logic [7:0] cks);
        tx.delete();
        tx.push_back(8'h00); tx.push_back(8'h02);
        tx.push_back(8'h20); tx.push_back(8'h08); tx.push_back(8'h00); tx.push_back(8'h05);
        tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00);
        tx.push_back(cks);
    endtask

    task automatic build_frame(input int n);
        logic [7:0] b;
        logic [7:0] x;
        tx.delete();
        tx.push_back(8'((n >> 8) & 255));
        tx.push_back(8'(n & 255));
        x = 8'h00;
        repeat (4 * n) begin
            b = 8'($urandom);
            x ^= b;
            tx.push_back(b);
        end
        tx.push_back(x);
    endtask

    int wr_start;
    int n_cyc;
    int n_words;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        check("rst_in_ready", in_ready, 0);
        check("rst_im_we", im_we, 0);
        check("rst_im_waddr", im_waddr, 0);
        check("rst_im_wdata", im_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_words_loaded", words_loaded, 0);
        reset = 1'b0;
        step();

        // Two-word frame with correct checksum 0x2D.
        pulse_start();
        wr_start = wr_addr_log.size();
        frame_a(8'h2D);
        send_tx(0, -1);
        check("a_done", done, 1);
        check("a_cpu_reset", cpu_reset, 0);
        check("a_words_loaded", words_loaded, 2);
        check("a_write_count", wr_addr_log.size() - wr_start, 2);
        if (wr_addr_log.size() - wr_start == 2) begin
            check("a_w0_addr", wr_addr_log[wr_start], 0);
            check("a_w0_data", wr_data_log[wr_start], 32'h2008_0005);
            check("a_w1_addr", wr_addr_log[wr_start+1], 1);
            check("a_w1_data", wr_data_log[wr_start+1], 32'h0000_0000);
        end

        // Bad checksum, then recovery with the good frame.
        pulse_start();
        frame_a(8'h2C);
        send_tx(0, -1);
        check("bad_cks_error", error, 1);
        check("bad_cks_cpu_reset", cpu_reset, 1);
        check("bad_cks_done", done, 0);
        pulse_start();
        frame_a(8'h2D);
        send_tx(1, -1);
        check("recover_done", done, 1);
        check("recover_error", error, 0);

        // Empty image: good and bad checksum.
        pulse_start();
        wr_start = wr_addr_log.size();
        tx.delete(); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h00);
        send_tx(0, -1);
        check("empty_writes", wr_addr_log.size() - wr_start, 0);
        check("empty_done", done, 1);
        check("empty_words_loaded", words_loaded, 0);
        pulse_start();
        tx.delete(); tx.push_back(8'h00); tx.push_back(8'h00); tx.push_back(8'h01);
        send_tx(0, -1);
        check("empty_bad_error", error, 1);

        // Oversized length is rejected right after the second length byte.
        pulse_start();
        wr_start = wr_addr_log.size();
        tx.delete(); tx.push_back(8'h01); tx.push_back(8'h01);
        send_tx(0, -1);
        check("oversize_error", error, 1);
        check("oversize_in_ready", in_ready, 0);
        check("oversize_writes", wr_addr_log.size() - wr_start, 0);

        // Full-capacity image.
        pulse_start();
        wr_start = wr_addr_log.size();
        build_frame(CAP);
        send_tx(2, -1);
        check("full_done", done, 1);
        check("full_words_loaded", words_loaded, 9'h100);
        n_words = wr_addr_log.size() - wr_start;
        check("full_write_count", n_words, 256);
        if (n_words > 0) check("full_last_addr", wr_addr_log[wr_addr_log.size()-1], 8'hFF);

        // Timeout: two of four payload bytes, then silence.
        pulse_start();
        tx.delete();
        tx.push_back(8'h00); tx.push_back(8'h01); tx.push_back(8'hAA); tx.push_back(8'hBB);
        send_tx(0, -1);
        n_cyc = 0;
        while (error !== 1'b1 && n_cyc < 40) begin
            step();
            n_cyc++;
        end
        check("timeout_cycles", n_cyc, TIMEOUT);
        check("timeout_error", error, 1);

        // Random frames with gaps below the timeout; one gets a start pulse during DATA.
        for (int r = 0; r < 4; r++) begin
            n_words = int'($urandom_range(8, 1));
            pulse_start();
            build_frame(n_words);
            send_tx(10, (r == 1) ? 4 : -1);
            check("rand_done", done, 1);
            check("rand_words_loaded", words_loaded, n_words);
        end

        // Reset sampled together with a word's 4th byte cancels the pending write.
        pulse_start();
        tx.delete();
        tx.push_back(8'h00); tx.push_back(8'h02);
        tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
        send_tx(0, -1);
        in_valid = 1'b1;
        in_data  = 8'h44;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        check("midrst_im_we", im_we, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_cpu_reset", cpu_reset, 1);
        check("midrst_done", done, 0);
        check("midrst_error", error, 0);
        check("midrst_words_loaded", words_loaded, 0);
        check("midrst_im_waddr", im_waddr, 0);
        check("midrst_im_wdata", im_wdata, 0);
        step();
        pulse_start();
        build_frame(3);
        send_tx(3, -1);
        check("after_rst_done", done, 1);
        check("after_rst_words_loaded", words_loaded, 3);

        step();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
